clk_div_multi: RTL and testbench

//   Parametrised N-channel clock divider / tick generator for the traffic-pedestrian controller.

---
 rtl/clk_div_multi.sv | 100 ++++++++++
 tb/tb_clk_div_multi.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider / tick generator with shadowed divisor updates.
// Latency: first tick on the D-th rising edge after enable; all outputs registered.
// No backpressure: free-running per channel, divisor writes always accepted (bad select dropped).
module clk_div_multi #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 27,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {27'd100_000_000, 27'd50_000_000},
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] ch_mode,
   input  logic              sync_restart,
   input  logic              div_wr,
   input  logic [SEL_W-1:0]  div_sel,
   input  logic [CNT_W-1:0]  div_val,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] div_pend
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [CNT_W-1:0] INIT_D = DIV_INIT[i*CNT_W +: CNT_W];

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] act_q;
      logic [CNT_W-1:0] shd_q;
      logic             co_q;
      logic             tk_q;
      logic             pend_q;
      logic             mode_q;

      logic             wr_hit;
      logic [CNT_W-1:0] d_eff;
      logic             term;
      logic [CNT_W-1:0] shd_nxt;
      logic             mode_chg;

      // Out-of-range selects never match any channel index, so they are dropped here.
      assign wr_hit   = div_wr && (div_sel == SEL_W'(i));
      // A programmed divisor of 0 behaves as 1.
      assign d_eff    = (act_q == '0) ? CNT_W'(1) : act_q;
      // >= rather than == so a counter beyond a shrunken divisor still terminates.
      assign term     = (cnt_q >= (d_eff - CNT_W'(1)));
      assign shd_nxt  = wr_hit ? div_val : shd_q;
      assign mode_chg = (ch_mode[i] != mode_q);

      // Per-channel counter, divisor shadow/active pair and registered outputs.
      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q  <= '0;
            act_q  <= INIT_D;
            shd_q  <= INIT_D;
            co_q   <= 1'b0;
            tk_q   <= 1'b0;
            pend_q <= 1'b0;
            mode_q <= 1'b0;
         end else begin
            mode_q <= ch_mode[i];
            if (sync_restart || !ch_en[i]) begin
               // Idle or realign: phase 0, and any pending divisor (including one
               // written this very cycle) becomes active right away.
               cnt_q  <= '0;
               co_q   <= 1'b0;
               tk_q   <= 1'b0;
               shd_q  <= shd_nxt;
               act_q  <= shd_nxt;
               pend_q <= 1'b0;
            end else if (term) begin
               // Period boundary: the only point where a new divisor may take over,
               // so the period just finished always ran at the old divisor.
               cnt_q  <= '0;
               tk_q   <= 1'b1;
               act_q  <= shd_q;
               shd_q  <= shd_nxt;
               pend_q <= wr_hit;
               if (mode_chg)
                  co_q <= 1'b0;
               else if (ch_mode[i])
                  co_q <= 1'b1;
               else
                  co_q <= ~co_q;
            end else begin
               cnt_q  <= cnt_q + CNT_W'(1);
               tk_q   <= 1'b0;
               shd_q  <= shd_nxt;
               pend_q <= pend_q | wr_hit;
               if (mode_chg || ch_mode[i])
                  co_q <= 1'b0;
            end
         end
      end

      assign clk_out[i]  = co_q;
      assign tick[i]     = tk_q;
      assign div_pend[i] = pend_q;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus a randomized run against a behavioural model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Three channels are used so that an out-of-range divisor select is representable.
module tb_clk_div_multi;

   localparam int NCH = 3;
   localparam int CW  = 8;
   localparam logic [NCH*CW-1:0] INIT = {8'd5, 8'd4, 8'd3};

   logic           clk_in = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] ch_en;
   logic [NCH-1:0] ch_mode;
   logic           sync_restart;
   logic           div_wr;
   logic [1:0]     div_sel;
   logic [CW-1:0]  div_val;
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] div_pend;

   int checks = 0;
   int errors = 0;

   // Behavioural model: position within the current period, divisor values as integers.
   int m_pos  [NCH];
   int m_act  [NCH];
   int m_shd  [NCH];
   bit m_pend [NCH];
   bit m_co   [NCH];
   bit m_tk   [NCH];
   bit m_mprev[NCH];

   clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DIV_INIT(INIT)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .ch_en(ch_en), .ch_mode(ch_mode),
      .sync_restart(sync_restart), .div_wr(div_wr), .div_sel(div_sel), .div_val(div_val),
      .clk_out(clk_out), .tick(tick), .div_pend(div_pend)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_pos[i]   = 0;
         m_act[i]   = int'(INIT[i*CW +: CW]);
         m_shd[i]   = m_act[i];
         m_pend[i]  = 1'b0;
         m_co[i]    = 1'b0;
         m_tk[i]    = 1'b0;
         m_mprev[i] = 1'b0;
      end
   endtask

   // Advance the model by one rising edge using the inputs currently applied.
   task automatic model_update();
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NCH; i++) begin
         bit wr;
         int period;
         wr     = div_wr && (int'(div_sel) == i);
         period = (m_act[i] == 0) ? 1 : m_act[i];
         if (sync_restart || !ch_en[i]) begin
            if (wr) m_shd[i] = int'(div_val);
            m_act[i]  = m_shd[i];
            m_pend[i] = 1'b0;
            m_pos[i]  = 0;
            m_co[i]   = 1'b0;
            m_tk[i]   = 1'b0;
         end else if (m_pos[i] + 1 >= period) begin
            m_act[i]  = m_shd[i];
            if (wr) m_shd[i] = int'(div_val);
            m_pend[i] = wr;
            m_pos[i]  = 0;
            m_tk[i]   = 1'b1;
            m_co[i]   = ch_mode[i] ? 1'b1 : !m_co[i];
         end else begin
            m_pos[i]++;
            m_tk[i] = 1'b0;
            if (ch_mode[i]) m_co[i] = 1'b0;
            if (wr) begin
               m_shd[i]  = int'(div_val);
               m_pend[i] = 1'b1;
            end
         end
         if (ch_mode[i] != m_mprev[i]) m_co[i] = 1'b0;
         m_mprev[i] = ch_mode[i];
      end
   endtask

   task automatic check_all(input string tag);
      logic [NCH-1:0] e_tk, e_co, e_pd;
      for (int i = 0; i < NCH; i++) begin
         e_tk[i] = m_tk[i];
         e_co[i] = m_co[i];
         e_pd[i] = m_pend[i];
      end
      chk({tag, ".tick"}, 32'(tick), 32'(e_tk));
      chk({tag, ".clk_out"}, 32'(clk_out), 32'(e_co));
      chk({tag, ".div_pend"}, 32'(div_pend), 32'(e_pd));
   endtask

   task automatic step(input string tag);
      model_update();
      @(posedge clk_in);
      #1;
      check_all(tag);
   endtask

   task automatic idle_in();
      sync_restart = 1'b0;
      div_wr       = 1'b0;
      div_sel      = 2'd0;
      div_val      = '0;
   endtask

   initial begin
      int first_tk[NCH];
      int n_tk0;
      int t_last;
      int found;
      int gaps[2];

      rst_n = 1'b0; ch_en = '0; ch_mode = '0;
      idle_in();
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      check_all("reset");

      // Power-up timing with the reset divisors 3/4/5 in toggle mode.
      rst_n = 1'b1;
      ch_en = 3'b111;
      for (int i = 0; i < NCH; i++) first_tk[i] = 0;
      n_tk0 = 0;
      for (int e = 1; e <= 12; e++) begin
         step("startup");
         for (int i = 0; i < NCH; i++)
            if (tick[i] && first_tk[i] == 0) first_tk[i] = e;
         if (tick[0]) n_tk0++;
      end
      chk("first_tick0", 32'(first_tk[0]), 32'd3);
      chk("first_tick1", 32'(first_tk[1]), 32'd4);
      chk("first_tick2", 32'(first_tk[2]), 32'd5);
      chk("tick0_count_12", 32'(n_tk0), 32'd4);

      // Divisor change mid-period: old period completes, then the new spacing.
      found = 0;
      for (int k = 0; k < 10 && found == 0; k++) begin
         step("seek_tick0");
         if (tick[0]) found = 1;
      end
      chk("seek_tick0_timeout", 32'(found), 32'd1);
      step("cnt1");
      div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd5;
      step("wr_ch0_5");
      idle_in();
      chk("pend0_after_wr", 32'(div_pend[0]), 32'd1);
      t_last = 0;
      gaps[0] = 0; gaps[1] = 0;
      found = 0;
      for (int e = 1; e <= 20 && found < 2; e++) begin
         step("gap_watch");
         if (tick[0]) begin
            gaps[found] = e - t_last;
            t_last = e;
            found++;
         end
      end
      chk("gap_old_d", 32'(gaps[0]), 32'd1);
      chk("gap_new_d", 32'(gaps[1]), 32'd5);
      chk("pend0_cleared", 32'(div_pend[0]), 32'd0);

      // Pulse mode on ch1, then divisor 0 acting as 1.
      ch_mode[1] = 1'b1;
      repeat (9) step("pulse_d4");
      div_wr = 1'b1; div_sel = 2'd1; div_val = 8'd0;
      step("wr_ch1_0");
      idle_in();
      repeat (6) step("pulse_settle");
      for (int k = 0; k < 4; k++) begin
         step("pulse_d1");
         chk("d1_tick1_high", 32'(tick[1]), 32'd1);
         chk("d1_clk1_high", 32'(clk_out[1]), 32'd1);
      end

      // Out-of-range select must be ignored; back-to-back writes keep the last value.
      div_wr = 1'b1; div_sel = 2'd3; div_val = 8'd7;
      step("bad_sel");
      chk("bad_sel_no_pend", 32'(div_pend), 32'd0);
      div_sel = 2'd2; div_val = 8'd6;
      step("b2b_a");
      div_val = 8'd2;
      step("b2b_b");
      idle_in();
      repeat (14) step("b2b_run");

      // Global restart with a same-cycle write applied immediately.
      sync_restart = 1'b1; div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd4;
      step("restart");
      idle_in();
      chk("restart_outs", 32'({tick, clk_out, div_pend}), 32'd0);
      repeat (12) step("post_restart");

      // Disable with a pending write, then re-enable.
      div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd2;
      step("wr_before_dis");
      idle_in();
      ch_en[0] = 1'b0;
      step("disable0");
      chk("dis_pend0", 32'(div_pend[0]), 32'd0);
      chk("dis_tick_clk0", 32'({tick[0], clk_out[0]}), 32'd0);
      repeat (3) step("disabled");
      ch_en[0] = 1'b1;
      repeat (8) step("reenable");

      // Randomized run.
      for (int k = 0; k < 600; k++) begin
         idle_in();
         if ($urandom_range(0, 99) < 8) ch_en[$urandom_range(0, NCH-1)] ^= 1'b1;
         if ($urandom_range(0, 99) < 4) ch_mode[$urandom_range(0, NCH-1)] ^= 1'b1;
         if ($urandom_range(0, 99) < 2) sync_restart = 1'b1;
         if ($urandom_range(0, 99) < 10) begin
            div_wr  = 1'b1;
            div_sel = 2'($urandom_range(0, 3));
            div_val = 8'($urandom_range(0, 7));
         end
         step("random");
      end
      idle_in();

      // Asynchronous reset mid-run: outputs drop before any clock edge.
      ch_en = 3'b111;
      repeat (5) step("pre_arst");
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all("async_reset");
      step("in_reset");
      rst_n = 1'b1;
      ch_mode = '0;
      repeat (20) step("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
